// File: rtl/router_pkg.sv
// Shared definitions for the router ingress arbiter.
// Header byte layout: {len[7:2], addr[1:0]}; addr 2'b11 names a port that
// does not exist, so such packets are consumed from the source and discarded.
package router_pkg;

    localparam int unsigned DATA_W   = 8;

    localparam int unsigned LEN_MSB  = 7;
    localparam int unsigned LEN_LSB  = 2;
    localparam int unsigned LEN_W    = LEN_MSB - LEN_LSB + 1;
    localparam int unsigned ADDR_MSB = 1;
    localparam int unsigned ADDR_LSB = 0;

    localparam logic [1:0] ADDR_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PLD,
        PAR,
        GAP,
        DROP
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
// Ports:
//   req_i  - request vector, one bit per source
//   ptr_i  - index searched first; the search wraps past NUM_SRC-1 to 0
//   gnt_o  - one-hot grant (all zero when nothing requests)
//   idx_o  - index of the granted source
//   any_o  - at least one request present
module rr_arbiter #(
    parameter int unsigned NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0]         req_i,
    input  logic [$clog2(NUM_SRC)-1:0] ptr_i,
    output logic [NUM_SRC-1:0]         gnt_o,
    output logic [$clog2(NUM_SRC)-1:0] idx_o,
    output logic                       any_o
);

    localparam int unsigned IW = $clog2(NUM_SRC);

    logic [IW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            cand = IW'((32'(ptr_i) + i) % NUM_SRC);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/router_ingress_arbiter.sv
// Round-robin ingress scheduler for the 1x3 router.
// Grants one source per packet, forwards header and payload bytes to the
// router, appends the XOR parity byte, and discards packets addressed to 2'b11.
// Ports:
//   clock, reset   - rising-edge clock, synchronous active-high reset
//   src_valid      - per-source byte available on src_data
//   src_data       - source s byte at [s*DATA_W +: DATA_W]
//   src_ready      - per-source: byte consumed at this edge
//   rtr_busy       - router stall; nothing advances while high
//   rtr_pkt_valid  - registered pkt_valid to router
//   rtr_data       - registered data_in to router
//   grant_id       - source owning the current packet
//   pkt_done       - pulse when the parity byte is issued
//   drop_err       - pulse when an illegal-address packet has been discarded
//   proto_err      - pulse when a filler byte replaces a missing payload byte
module router_ingress_arbiter #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned DATA_W  = router_pkg::DATA_W
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_SRC-1:0]           src_valid,
    input  logic [NUM_SRC*DATA_W-1:0]    src_data,
    output logic [NUM_SRC-1:0]           src_ready,
    input  logic                         rtr_busy,
    output logic                         rtr_pkt_valid,
    output logic [DATA_W-1:0]            rtr_data,
    output logic [$clog2(NUM_SRC)-1:0]   grant_id,
    output logic                         pkt_done,
    output logic                         drop_err,
    output logic                         proto_err
);

    import router_pkg::*;

    localparam int unsigned IW = $clog2(NUM_SRC);

    state_e             state_q;
    logic [IW-1:0]      grant_q;
    logic [NUM_SRC-1:0] gnt_oh_q;
    logic [IW-1:0]      rr_ptr_q;
    logic [LEN_W-1:0]   len_cnt_q;
    logic [DATA_W-1:0]  par_q;
    logic [DATA_W-1:0]  data_q;
    logic               vld_q;
    logic               done_q;
    logic               drop_q;
    logic               proto_q;

    logic               adv;
    logic [NUM_SRC-1:0] arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;
    logic               g_valid;
    logic [DATA_W-1:0]  g_byte;
    logic [DATA_W-1:0]  pld_byte;
    logic [LEN_W-1:0]   hdr_len;
    logic [1:0]         hdr_addr;
    logic [IW-1:0]      ptr_next;
    logic               accept_state;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC)
    ) u_rr_arbiter (
        .req_i (src_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // Byte/valid of the granted source, selected by the registered one-hot grant.
    always_comb begin
        g_byte  = '0;
        g_valid = 1'b0;
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
            if (gnt_oh_q[s]) begin
                g_byte  = src_data[s*DATA_W +: DATA_W];
                g_valid = src_valid[s];
            end
        end
    end

    always_comb begin
        adv      = !rtr_busy;
        pld_byte = g_valid ? g_byte : '0;
        hdr_len  = g_byte[LEN_MSB:LEN_LSB];
        hdr_addr = g_byte[ADDR_MSB:ADDR_LSB];
        ptr_next = (grant_q == IW'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;
        // DROP also acknowledges bytes, otherwise the discarded payload could
        // never leave the source.
        accept_state = (state_q == HDR) || (state_q == PLD) ||
                       ((state_q == DROP) && (len_cnt_q != '0));
        src_ready    = (accept_state && adv) ? gnt_oh_q : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            gnt_oh_q  <= '0;
            rr_ptr_q  <= '0;
            len_cnt_q <= '0;
            par_q     <= '0;
            data_q    <= '0;
            vld_q     <= 1'b0;
            done_q    <= 1'b0;
            drop_q    <= 1'b0;
            proto_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
            proto_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (arb_any) begin
                        grant_q  <= arb_idx;
                        gnt_oh_q <= arb_gnt;
                        state_q  <= HDR;
                    end
                end
                HDR: begin
                    if (adv && g_valid) begin
                        par_q     <= g_byte;
                        len_cnt_q <= hdr_len;
                        if (hdr_addr == ADDR_ILLEGAL) begin
                            state_q <= DROP;
                        end else begin
                            data_q  <= g_byte;
                            vld_q   <= 1'b1;
                            state_q <= (hdr_len == '0) ? PAR : PLD;
                        end
                    end
                end
                PLD: begin
                    // A missing source byte still occupies a payload slot as 0x00.
                    if (adv) begin
                        data_q    <= pld_byte;
                        vld_q     <= 1'b1;
                        par_q     <= par_q ^ pld_byte;
                        len_cnt_q <= len_cnt_q - 1'b1;
                        proto_q   <= !g_valid;
                        if (len_cnt_q == LEN_W'(1)) begin
                            state_q <= PAR;
                        end
                    end
                end
                PAR: begin
                    if (adv) begin
                        data_q   <= par_q;
                        vld_q    <= 1'b0;
                        done_q   <= 1'b1;
                        rr_ptr_q <= ptr_next;
                        state_q  <= GAP;
                    end
                end
                GAP: begin
                    if (adv) begin
                        data_q  <= '0;
                        state_q <= IDLE;
                    end
                end
                DROP: begin
                    if (len_cnt_q == '0) begin
                        drop_q   <= 1'b1;
                        rr_ptr_q <= ptr_next;
                        state_q  <= IDLE;
                    end else if (adv && g_valid) begin
                        len_cnt_q <= len_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rtr_pkt_valid = vld_q;
    assign rtr_data      = data_q;
    assign grant_id      = grant_q;
    assign pkt_done      = done_q;
    assign drop_err      = drop_q;
    assign proto_err     = proto_q;

endmodule
